// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared X-interface definitions: result merge defaults and the packed result width,
// so RTL and bench agree on the {id, data, rd, we, float, exc, exccode} packing.
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_RES_MERGE_CH    = 2;
  localparam int unsigned X_RES_MERGE_DEPTH = 2;

  function automatic int unsigned x_res_width(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w + 5 + data_w / 32 + 1 + 1 + 6;
  endfunction

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Single-channel result buffer: wrap-bit pointers, flush beats push/pop, no bypass.
module cv32e40p_x_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Payload storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cv32e40p_x_result_merge.sv
// Merges NUM_CH coprocessor result streams onto the core X result channel with a locked
// round-robin arbiter; define CV32E40P_X_RESULT_FIXED_PRIO_EN for lowest-index-wins priority.
module cv32e40p_x_result_merge
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned NUM_CH     = X_RES_MERGE_CH,
  parameter int unsigned FIFO_DEPTH = X_RES_MERGE_DEPTH,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WE_WIDTH   = DATA_WIDTH / 32,
  // The package width assumes one we bit per word; an overridden WE_WIDTH is folded in here.
  localparam int unsigned RES_W = x_res_width(ID_WIDTH, DATA_WIDTH) - DATA_WIDTH / 32 + WE_WIDTH,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned OCC_W = $clog2(NUM_CH * FIFO_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [NUM_CH-1:0]              ch_valid_i,
  output logic [NUM_CH-1:0]              ch_ready_o,
  input  logic [NUM_CH-1:0][RES_W-1:0]   ch_result_i,
  output logic                           result_valid_o,
  input  logic                           result_ready_i,
  output logic [RES_W-1:0]               result_o,
  output logic [CH_W-1:0]                result_ch_o,
  output logic [OCC_W-1:0]               occupancy_o
);

  logic [NUM_CH-1:0]             full, empty, push, pop;
  logic [NUM_CH-1:0][RES_W-1:0]  head;
  logic [CH_W-1:0]               grant;
  logic                          hs;
  logic                          lock_q, lock_d;
  logic [CH_W-1:0]               lock_ch_q, lock_ch_d;
  logic [OCC_W-1:0]              occ_q, occ_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    cv32e40p_x_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RES_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  (ch_result_i[c]),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  assign ch_ready_o     = ~full;
  assign push           = ch_valid_i & ~full & {NUM_CH{~flush_i}};
  assign result_valid_o = |(~empty);
  assign hs             = result_valid_o && result_ready_i;
  assign result_o       = result_valid_o ? head[grant] : '0;

  if (NUM_CH == 1) begin : g_single
    assign result_ch_o = '0;
  end else begin : g_multi
    assign result_ch_o = grant;
  end

`ifdef CV32E40P_X_RESULT_FIXED_PRIO_EN
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !empty[i]) begin
        grant = CH_W'(i);
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_ch_q;
  end
`else
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  // Search starts at the pointer and wraps, so the last-served channel goes to the back.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr_q) + 32'(i)) % NUM_CH;
      if (!found && !empty[idx]) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_ch_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush_i)  rr_ptr_d = '0;
    else if (hs)  rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) pop[c] = hs && !flush_i && (grant == CH_W'(c));
  end

  // A stalled output freezes its grant so result_o cannot change under the core.
  assign lock_d    = result_valid_o && !result_ready_i && !flush_i;
  assign lock_ch_d = grant;

  always_comb begin
    occ_d = occ_q;
    for (int c = 0; c < NUM_CH; c++) occ_d = occ_d + OCC_W'(push[c]);
    if (hs)      occ_d = occ_d - OCC_W'(1);
    if (flush_i) occ_d = '0;
  end

  assign occupancy_o = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      occ_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_result_merge.sv
// Bench for cv32e40p_x_result_merge: directed vector table, hand sequences for stall,
// lock and reset, then random traffic against a queue-based reference model.
module tb_cv32e40p_x_result_merge;
  import cv32e40p_core_v_xif_pkg::*;

  localparam int NCH = 2;
  localparam int DEP = 2;
  localparam int RW  = x_res_width(4, 32);
  localparam int OW  = $clog2(NCH * DEP + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [NCH-1:0]         ch_valid;
  logic [NCH-1:0]         ch_ready;
  logic [NCH-1:0][RW-1:0] ch_res;
  logic                   res_valid;
  logic                   res_ready;
  logic [RW-1:0]          res;
  logic [0:0]             res_ch;
  logic [OW-1:0]          occ;

  int n_vec = 0;
  int n_err = 0;

  cv32e40p_x_result_merge #(
    .NUM_CH (NCH), .FIFO_DEPTH (DEP), .ID_WIDTH (4), .DATA_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .ch_valid_i     (ch_valid),
    .ch_ready_o     (ch_ready),
    .ch_result_i    (ch_res),
    .result_valid_o (res_valid),
    .result_ready_i (res_ready),
    .result_o       (res),
    .result_ch_o    (res_ch),
    .occupancy_o    (occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic [1:0] vld;
    logic       rdy;
    logic [3:0] id0;
    logic [3:0] id1;
    logic       e_vld;
    logic       e_ch;
    logic [3:0] e_id;
    int         e_occ;
    logic [1:0] e_crdy;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [RW-1:0] mk(input logic [3:0] id, input logic ch);
    logic [31:0] d;
    d = 32'hDEADBEEF ^ {24'h0, 3'b000, ch, id ^ 4'd3};
    return {id, d, 1'b0, id, 1'b1, 1'b0, 1'b0, 6'd0};
  endfunction

  function automatic vec_t mkv(input logic f, input logic [1:0] v, input logic r,
                               input logic [3:0] i0, input logic [3:0] i1,
                               input logic ev, input logic ec, input logic [3:0] ei,
                               input int eo, input logic [1:0] er);
    vec_t t;
    t.flush = f; t.vld = v; t.rdy = r; t.id0 = i0; t.id1 = i1;
    t.e_vld = ev; t.e_ch = ec; t.e_id = ei; t.e_occ = eo; t.e_crdy = er;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: per-channel queues, rotating start pointer, held choice.
  logic [RW-1:0] mq [NCH][$];
  int  rr;
  int  held_ch;
  bit  held;

  function automatic int pick();
    int c;
    if (held) return held_ch;
    for (int i = 0; i < NCH; i++) begin
`ifdef CV32E40P_X_RESULT_FIXED_PRIO_EN
      c = i;
`else
      c = (rr + i) % NCH;
`endif
      if (mq[c].size() > 0) return c;
    end
    return 0;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; ch_valid = '0; res_ready = 1'b0; ch_res = '0;

    tbl[0]  = mkv(0, 2'b01, 1, 4'd3, 4'd0, 0, 0, 4'd0, 0, 2'b11);
    tbl[1]  = mkv(0, 2'b00, 1, 4'd0, 4'd0, 1, 0, 4'd3, 1, 2'b11);
    tbl[2]  = mkv(1, 2'b00, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 2'b11);
    tbl[3]  = mkv(0, 2'b11, 0, 4'd1, 4'd5, 0, 0, 4'd0, 0, 2'b11);
    tbl[4]  = mkv(0, 2'b11, 0, 4'd2, 4'd6, 1, 0, 4'd1, 2, 2'b11);
    tbl[5]  = mkv(0, 2'b00, 1, 4'd0, 4'd0, 1, 0, 4'd1, 4, 2'b00);
`ifdef CV32E40P_X_RESULT_FIXED_PRIO_EN
    tbl[6]  = mkv(0, 2'b00, 1, 4'd0, 4'd0, 1, 0, 4'd2, 3, 2'b01);
    tbl[7]  = mkv(0, 2'b00, 1, 4'd0, 4'd0, 1, 1, 4'd5, 2, 2'b11);
`else
    tbl[6]  = mkv(0, 2'b00, 1, 4'd0, 4'd0, 1, 1, 4'd5, 3, 2'b01);
    tbl[7]  = mkv(0, 2'b00, 1, 4'd0, 4'd0, 1, 0, 4'd2, 2, 2'b11);
`endif
    tbl[8]  = mkv(0, 2'b00, 0, 4'd0, 4'd0, 1, 1, 4'd6, 1, 2'b11);
    tbl[9]  = mkv(0, 2'b11, 0, 4'd7, 4'd8, 0, 0, 4'd0, 0, 2'b11);
    tbl[10] = mkv(0, 2'b01, 0, 4'd9, 4'd0, 1, 0, 4'd7, 2, 2'b11);
    tbl[11] = mkv(1, 2'b10, 1, 4'd0, 4'd10, 1, 0, 4'd7, 3, 2'b10);
    tbl[12] = mkv(0, 2'b00, 1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 2'b11);
    tbl[13] = mkv(0, 2'b00, 1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 2'b11);
    // Row 8 must still see ready=1 to pop the last entry.
    tbl[8].rdy = 1'b1;

    #2;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_result", 64'(res), 64'd0);
    chk("rst_ch", 64'(res_ch), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_ch_ready", 64'(ch_ready), 64'h3);
    #10 rst_n = 1'b1;
    edge1();

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl%0d_valid", i), 64'(res_valid), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_result", i), 64'(res),
          tbl[i].e_vld ? 64'(mk(tbl[i].e_id, tbl[i].e_ch)) : 64'd0);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_ch", i), 64'(res_ch), 64'(tbl[i].e_ch));
      chk($sformatf("tbl%0d_occ", i), 64'(occ), 64'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_ch_ready", i), 64'(ch_ready), 64'(tbl[i].e_crdy));
      flush     = tbl[i].flush;
      ch_valid  = tbl[i].vld;
      res_ready = tbl[i].rdy;
      ch_res[0] = mk(tbl[i].id0, 1'b0);
      ch_res[1] = mk(tbl[i].id1, 1'b1);
      edge1();
    end
    flush = 1'b0; ch_valid = '0; res_ready = 1'b0;

    // Backpressure: fill ch0, keep offering a third entry while the output stalls.
    ch_valid = 2'b01; ch_res[0] = mk(4'd1, 1'b0);
    edge1();
    ch_res[0] = mk(4'd2, 1'b0);
    edge1();
    chk("bp_ch_ready_full", 64'(ch_ready), 64'h2);
    ch_res[0] = mk(4'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk("bp_hold_result", 64'(res), 64'(mk(4'd1, 1'b0)));
      chk("bp_hold_ch", 64'(res_ch), 64'd0);
      chk("bp_hold_occ", 64'(occ), 64'd2);
    end
    ch_valid = 2'b00; res_ready = 1'b1;
    edge1();
    chk("bp_second", 64'(res), 64'(mk(4'd2, 1'b0)));
    chk("bp_second_occ", 64'(occ), 64'd1);
    edge1();
    chk("bp_drained", 64'(res_valid), 64'd0);
    res_ready = 1'b0;

    // Grant lock: ch1 stalls, ch0 arrives with the search pointer at 0.
    flush = 1'b1;
    edge1();
    flush = 1'b0; ch_valid = 2'b10; ch_res[1] = mk(4'd4, 1'b1);
    edge1();
    chk("lock_first_ch", 64'(res_ch), 64'd1);
    ch_valid = 2'b01; ch_res[0] = mk(4'd5, 1'b0);
    edge1();
    ch_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("lock_hold_ch", 64'(res_ch), 64'd1);
      chk("lock_hold_result", 64'(res), 64'(mk(4'd4, 1'b1)));
      edge1();
    end
    res_ready = 1'b1;
    chk("lock_hs_ch", 64'(res_ch), 64'd1);
    edge1();
    chk("lock_then_ch0", 64'(res_ch), 64'd0);
    chk("lock_then_ch0_result", 64'(res), 64'(mk(4'd5, 1'b0)));
    edge1();
    chk("lock_drained", 64'(res_valid), 64'd0);
    res_ready = 1'b0;

    // Asynchronous reset in the middle of a stalled transfer.
    ch_valid = 2'b01; ch_res[0] = mk(4'd6, 1'b0);
    edge1();
    ch_valid = 2'b00;
    chk("ar_pre_valid", 64'(res_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(res_valid), 64'd0);
    chk("ar_result", 64'(res), 64'd0);
    chk("ar_occ", 64'(occ), 64'd0);
    chk("ar_ch_ready", 64'(ch_ready), 64'h3);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("ar_idle_valid", 64'(res_valid), 64'd0);
      chk("ar_idle_occ", 64'(occ), 64'd0);
    end

    // Random traffic against the reference model.
    rr = 0; held = 1'b0; held_ch = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit  ev;
      int  pk;
      int  tot;
      int  sz [NCH];
      logic [NCH-1:0] er;
      tot = 0;
      for (int c = 0; c < NCH; c++) begin
        sz[c] = mq[c].size();
        tot += sz[c];
        er[c] = (sz[c] < DEP);
      end
      ev = (tot > 0);
      pk = pick();
      chk("rnd_valid", 64'(res_valid), 64'(ev));
      if (ev) begin
        chk("rnd_result", 64'(res), 64'(mq[pk][0]));
        chk("rnd_ch", 64'(res_ch), 64'(pk));
      end
      chk("rnd_occ", 64'(occ), 64'(tot));
      chk("rnd_ch_ready", 64'(ch_ready), 64'(er));

      ch_valid  = NCH'($urandom());
      res_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++) ch_res[c] = RW'({$urandom(), $urandom()});
      @(posedge clk);

      if (flush) begin
        for (int c = 0; c < NCH; c++) mq[c].delete();
        rr = 0; held = 1'b0;
      end else begin
        if (ev && res_ready) begin
          void'(mq[pk].pop_front());
          rr = (pk + 1) % NCH;
          held = 1'b0;
        end else if (ev) begin
          held = 1'b1;
          held_ch = pk;
        end
        for (int c = 0; c < NCH; c++)
          if (ch_valid[c] && sz[c] < DEP) mq[c].push_back(ch_res[c]);
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
